// File: rtl/tnn_pkg.sv
// Shared TNN feature-interface defaults, lane/vector types and the lane offset helper.
package tnn_pkg;

  localparam int TNN_FEAT_W = 3;
  localparam int TNN_N_FEAT = 6;

  typedef logic [TNN_FEAT_W-1:0]            feat_t;
  typedef logic [TNN_N_FEAT*TNN_FEAT_W-1:0] fvec_t;

  // Bit offset of lane i in a packed vector; lane 0 sits in the LSBs.
  function automatic int lane_off(input int i, input int w = TNN_FEAT_W);
    return i * w;
  endfunction

endpackage

// File: rtl/tnn_feat_quant.sv
// Narrows one IN_W-bit feature to FEAT_W bits; combinational, no backpressure.
// TNN_PACK_SAT_EN selects saturation to the lane maximum, otherwise upper bits are dropped.
module tnn_feat_quant #(
  parameter int IN_W   = 3,
  parameter int FEAT_W = 3
) (
  input  logic [IN_W-1:0]   din,
  output logic [FEAT_W-1:0] dout
);

  generate
    if (IN_W == FEAT_W) begin : g_pass
      assign dout = din;
    end else begin : g_narrow
`ifdef TNN_PACK_SAT_EN
      localparam logic [IN_W-1:0] MAX_V = IN_W'((1 << FEAT_W) - 1);
      assign dout = (din > MAX_V) ? {FEAT_W{1'b1}} : din[FEAT_W-1:0];
`else
      logic unused_hi;
      assign unused_hi = ^din[IN_W-1:FEAT_W];
      assign dout      = din[FEAT_W-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/tnn_feature_packer.sv
// Packs a serial feature stream into N_FEAT-lane vectors; m_valid rises the cycle after the completing beat.
// Two ping-pong slots: s_ready drops only while both slots wait on m_ready (quantiser mode: TNN_PACK_SAT_EN).
module tnn_feature_packer
  import tnn_pkg::*;
#(
  parameter int FEAT_W = TNN_FEAT_W,
  parameter int N_FEAT = TNN_N_FEAT,
  parameter int IN_W   = TNN_FEAT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_FEAT*FEAT_W-1:0] m_vec,
  output logic                     pack_err
);

  localparam int VEC_W = N_FEAT * FEAT_W;
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  logic [VEC_W-1:0]  slot [2];
  logic [1:0]        full;
  logic              wp;
  logic              rp;
  logic [IDX_W-1:0]  idx;

  logic [FEAT_W-1:0] q;
  logic [VEC_W-1:0]  wvec;
  logic              accept;
  logic              at_last;
  logic              done;
  logic              drain;

  tnn_feat_quant #(
    .IN_W   (IN_W),
    .FEAT_W (FEAT_W)
  ) u_quant (
    .din  (s_data),
    .dout (q)
  );

  assign s_ready = !full[wp];
  assign accept  = s_valid & s_ready;
  assign at_last = (idx == LAST_IDX);
  assign done    = accept & (s_last | at_last);
  assign m_valid = full[rp];
  assign m_vec   = slot[rp];
  assign drain   = m_valid & m_ready;

  // The first beat of a vector clears stale lanes so short vectors come out zero-padded.
  always_comb begin
    wvec = (idx == '0) ? '0 : slot[wp];
    for (int k = 0; k < N_FEAT; k++) begin
      if (idx == IDX_W'(k)) begin
        wvec[lane_off(k, FEAT_W) +: FEAT_W] = q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0]  <= '0;
      slot[1]  <= '0;
      full     <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      idx      <= '0;
      pack_err <= 1'b0;
    end else begin
      pack_err <= 1'b0;
      if (accept) begin
        slot[wp] <= wvec;
        if (done) begin
          full[wp] <= 1'b1;
          wp       <= ~wp;
          idx      <= '0;
          // Framing is clean only when s_last lands exactly on the final lane.
          pack_err <= (s_last != at_last);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      // A completing write targets an empty slot and a drain a full one, so they never collide.
      if (drain) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
      end
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Scoreboard bench for tnn_feature_packer: directed streams, expected vectors queued at issue time.
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [17:0] m_vec;
  logic        pack_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int e0;
  logic [17:0] exp_q [$];
  logic [17:0] mon_e;
  logic [17:0] v;
  logic [7:0]  t5_exp;

  tnn_feature_packer #(
    .FEAT_W (3),
    .N_FEAT (6),
    .IN_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_vec    (m_vec),
    .pack_err (pack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'o%0o expected 'o%0o", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the beat until s_ready, then steps past the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int b = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pack_err) err_seen++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vec: got 'o%0o expected none", m_vec);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vec", 32'(m_vec), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready_in_reset", 32'(s_ready), 1);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_m_valid_after", 32'(m_valid), 0);
    chk("rst_m_vec", 32'(m_vec), 0);
    chk("rst_pack_err", 32'(pack_err), 0);
    chk("rst_s_ready", 32'(s_ready), 1);

    // 1: clean 6-beat vector, immediate drain
    m_ready = 1'b1;
    e0 = err_seen;
    exp_q.push_back(18'o654321);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    chk("t1_m_valid_latency", 32'(m_valid), 1);
    chk("t1_m_vec_now", 32'(m_vec), 32'(18'o654321));
    chk("t1_pack_err", 32'(pack_err), 0);
    s_valid = 1'b0;
    cyc(4);
    chk("t1_err_count", 32'(err_seen - e0), 0);

    // 2: three back-to-back vectors against a stalled consumer
    m_ready = 1'b0;
    e0 = err_seen;
    for (int k = 0; k < 3; k++) begin
      v = '0;
      for (int j = 0; j < 6; j++) v[j*3 +: 3] = 3'((3*k + j) % 8);
      exp_q.push_back(v);
    end
    for (int n = 0; n < 12; n++) send(8'((3*(n/6) + n%6) % 8), (n % 6) == 5);
    s_valid = 1'b0;
    chk("t2_s_ready_drop", 32'(s_ready), 0);
    cyc(3);
    chk("t2_s_ready_held", 32'(s_ready), 0);
    chk("t2_m_valid_held", 32'(m_valid), 1);
    m_ready = 1'b1;
    cyc(1);
    chk("t2_s_ready_back", 32'(s_ready), 1);
    for (int n = 12; n < 18; n++) send(8'((3*(n/6) + n%6) % 8), (n % 6) == 5);
    s_valid = 1'b0;
    cyc(6);
    chk("t2_err_count", 32'(err_seen - e0), 0);

    // 3: short vector
    e0 = err_seen;
    exp_q.push_back(18'o000077);
    send(8'd7, 1'b0);
    send(8'd7, 1'b1);
    chk("t3_pack_err_pulse", 32'(pack_err), 1);
    s_valid = 1'b0;
    cyc(4);
    chk("t3_err_count", 32'(err_seen - e0), 1);

    // 4: missing s_last on two consecutive vectors
    e0 = err_seen;
    exp_q.push_back(18'o654321);
    exp_q.push_back(18'o543210);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    chk("t4_pack_err_b6", 32'(pack_err), 1);
    for (int i = 0; i <= 5; i++) send(8'(i), 1'b0);
    chk("t4_pack_err_b12", 32'(pack_err), 1);
    s_valid = 1'b0;
    cyc(4);
    chk("t4_err_count", 32'(err_seen - e0), 2);

    // 5: out-of-range input narrowed to one lane
`ifdef TNN_PACK_SAT_EN
    t5_exp = 8'd7;
`else
    t5_exp = 8'd5;
`endif
    e0 = err_seen;
    exp_q.push_back(18'(t5_exp));
    send(8'd13, 1'b1);
    s_valid = 1'b0;
    cyc(4);
    chk("t5_err_count", 32'(err_seen - e0), 1);

    // 6: reset with one full stalled slot and a partial vector in flight
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    for (int i = 1; i <= 3; i++) send(8'(i), 1'b0);
    s_valid = 1'b0;
    cyc(1);
    chk("t6_stalled_valid", 32'(m_valid), 1);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_m_valid_cleared", 32'(m_valid), 0);
    chk("t6_s_ready", 32'(s_ready), 1);
    chk("t6_m_vec_cleared", 32'(m_vec), 0);
    m_ready = 1'b1;
    e0 = err_seen;
    exp_q.push_back(18'o531642);
    send(8'd2, 1'b0);
    send(8'd4, 1'b0);
    send(8'd6, 1'b0);
    send(8'd1, 1'b0);
    send(8'd3, 1'b0);
    send(8'd5, 1'b1);
    s_valid = 1'b0;
    cyc(4);
    chk("t6_err_count", 32'(err_seen - e0), 0);

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) cyc(1);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
